ws2812b_frame_streamer: RTL and testbench



---
 rtl/ws2812b_frame_streamer_if.sv | 31 +++
 rtl/ws2812b_frame_streamer.sv | 203 ++++++++++++++++++++
 tb/tb_ws2812b_frame_streamer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812b_frame_streamer_if.sv
// Bus bundle between the frame streamer, the frame-buffer RAM and the parallel WS2812B output module.
// The master side is the streamer; the slave side groups the RAM read port and the LED-word consumer.
interface ws2812b_frame_streamer_if #(
    parameter int STRIPE_COUNT = 2,
    parameter int ADDR_WIDTH   = 14
);
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic                      mem_rd;
    logic [7:0]                mem_data;
    logic [24*STRIPE_COUNT-1:0] bitstream;
    logic                      bitstream_available;
    logic                      bitstream_read;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_data,
        output bitstream,
        output bitstream_available,
        input  bitstream_read
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_data,
        input  bitstream,
        input  bitstream_available,
        output bitstream_read
    );
endinterface

// File: rtl/ws2812b_frame_streamer.sv
// Walks the LED positions of one frame bank, packs the GRB bytes of all stripes into one word and
// prefetches the next word. Optional brightness scaling: define WS2812B_FRAME_STREAMER_BRIGHTNESS_EN.
module ws2812b_frame_streamer #(
    parameter int STRIPE_COUNT = 2,
    parameter int LED_COUNT    = 121,
    parameter int ADDR_WIDTH   = 14
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         bank_sel,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         start_dropped,
    input  logic [7:0]                   brightness,
    ws2812b_frame_streamer_if.master     bus
);
    localparam int NBYTES = 3 * STRIPE_COUNT;
    localparam int WORD_W = 24 * STRIPE_COUNT;
`ifdef WS2812B_FRAME_STREAMER_BRIGHTNESS_EN
    localparam int FETCH_LEN = NBYTES + 2;
`else
    localparam int FETCH_LEN = NBYTES + 1;
`endif
    localparam int CNT_W  = $clog2(FETCH_LEN);
    localparam int BYTE_W = $clog2(NBYTES);
    localparam int LED_W  = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;

    if (STRIPE_COUNT < 1 || STRIPE_COUNT > 8) begin : g_bad_stripe_count
        $error("STRIPE_COUNT must be in 1..8");
    end
    if (LED_COUNT < 1 || LED_COUNT > 1023) begin : g_bad_led_count
        $error("LED_COUNT must be in 1..1023");
    end
    if (3 * STRIPE_COUNT * LED_COUNT > (1 << (ADDR_WIDTH - 1))) begin : g_bank_overflow
        $error("frame does not fit into half of the address space");
    end

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [LED_W-1:0]        led_reg, led_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic                    done_reg, done_next;
    logic                    dropped_reg, dropped_next;

    logic                    rd_fire;
    logic                    load;
    logic                    consume;

    logic                    rd_d_reg;
    logic [BYTE_W-1:0]       idx_d_reg;
    logic                    cap_vld;
    logic [BYTE_W-1:0]       cap_idx;
    logic [7:0]              cap_byte;
    logic [7:0]              shadow_reg [NBYTES];
    logic [WORD_W-1:0]       shadow_word;
    logic [WORD_W-1:0]       out_reg;
    logic                    avail_reg;

    assign rd_fire = (state_reg == FETCH) && (cnt_reg < CNT_W'(NBYTES));
    assign load    = (state_reg == HOLD) && (!avail_reg || bus.bitstream_read);
    assign consume = avail_reg && bus.bitstream_read;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            led_reg     <= '0;
            addr_reg    <= '0;
            done_reg    <= 1'b0;
            dropped_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            led_reg     <= led_next;
            addr_reg    <= addr_next;
            done_reg    <= done_next;
            dropped_reg <= dropped_next;
        end
    end

    // The address register only advances between reads, so it keeps the last read address afterwards.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        led_next     = led_reg;
        addr_next    = addr_reg;
        done_next    = 1'b0;
        dropped_next = start && (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                    cnt_next   = '0;
                    led_next   = '0;
                    addr_next  = {bank_sel, {(ADDR_WIDTH-1){1'b0}}};
                end
            end
            FETCH: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg < CNT_W'(NBYTES - 1)) begin
                    addr_next = addr_reg + ADDR_WIDTH'(1);
                end
                if (cnt_reg == CNT_W'(FETCH_LEN - 1)) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (load) begin
                    if (led_reg == LED_W'(LED_COUNT - 1)) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = FETCH;
                        cnt_next   = '0;
                        led_next   = led_reg + LED_W'(1);
                        addr_next  = addr_reg + ADDR_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (consume) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef WS2812B_FRAME_STREAMER_BRIGHTNESS_EN
    logic [7:0]        bright_reg;
    logic              prod_vld_reg;
    logic [BYTE_W-1:0] prod_idx_reg;
    logic [7:0]        prod_byte_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            bright_reg    <= '0;
            prod_vld_reg  <= 1'b0;
            prod_idx_reg  <= '0;
            prod_byte_reg <= '0;
        end else begin
            if (start && state_reg == IDLE) begin
                bright_reg <= brightness;
            end
            prod_vld_reg  <= rd_d_reg;
            prod_idx_reg  <= idx_d_reg;
            prod_byte_reg <= 8'((16'(bus.mem_data) * (16'(bright_reg) + 16'd1)) >> 8);
        end
    end

    assign cap_vld  = prod_vld_reg;
    assign cap_idx  = prod_idx_reg;
    assign cap_byte = prod_byte_reg;
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;

    assign cap_vld  = rd_d_reg;
    assign cap_idx  = idx_d_reg;
    assign cap_byte = bus.mem_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_d_reg  <= 1'b0;
            idx_d_reg <= '0;
            out_reg   <= '0;
            avail_reg <= 1'b0;
            for (int i = 0; i < NBYTES; i++) begin
                shadow_reg[i] <= '0;
            end
        end else begin
            rd_d_reg  <= rd_fire;
            idx_d_reg <= cnt_reg[BYTE_W-1:0];
            if (cap_vld) begin
                shadow_reg[cap_idx] <= cap_byte;
            end
            // A load in the same cycle as a read keeps the word flow bubble-free.
            if (load) begin
                out_reg   <= shadow_word;
                avail_reg <= 1'b1;
            end else if (consume) begin
                avail_reg <= 1'b0;
            end
        end
    end

    // Byte b of the fetch belongs to stripe b/3, colour b%3 (G, R, B from the MSB down).
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_pack
        assign shadow_word[24*(gi/3) + 16 - 8*(gi%3) +: 8] = shadow_reg[gi];
    end

    assign bus.mem_addr            = addr_reg;
    assign bus.mem_rd              = rd_fire;
    assign bus.bitstream           = out_reg;
    assign bus.bitstream_available = avail_reg;
    assign busy                    = (state_reg != IDLE);
    assign frame_done              = done_reg;
    assign start_dropped           = dropped_reg;
endmodule

// File: tb/tb_ws2812b_frame_streamer.sv
// Directed bench for ws2812b_frame_streamer: 2 stripes, 3 LEDs, 8-bit addresses, RAM returns mem[a]=a.
// Expected words follow the brightness-scaled variant when WS2812B_FRAME_STREAMER_BRIGHTNESS_EN is defined.
module tb_ws2812b_frame_streamer;
    localparam int S  = 2;
    localparam int L  = 3;
    localparam int AW = 8;
`ifdef WS2812B_FRAME_STREAMER_BRIGHTNESS_EN
    localparam int EXP_LAT = 10;
`else
    localparam int EXP_LAT = 9;
`endif

    typedef struct {
        logic        bank;
        int          delay;
        bit          restart;
        int          hold;
        logic [47:0] w0;
        logic [47:0] w1;
        logic [47:0] w2;
    } vec_t;

    logic clk;
    logic reset;
    logic start;
    logic bank_sel;
    logic busy;
    logic frame_done;
    logic start_dropped;
    logic [7:0] brightness;
    logic rd_req;
    logic [7:0] mem_q;

    int tests;
    int fails;
    int rd_seen;
    int done_seen;

    vec_t tbl [5];

    ws2812b_frame_streamer_if #(.STRIPE_COUNT(S), .ADDR_WIDTH(AW)) bus ();

    ws2812b_frame_streamer #(.STRIPE_COUNT(S), .LED_COUNT(L), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .bank_sel      (bank_sel),
        .busy          (busy),
        .frame_done    (frame_done),
        .start_dropped (start_dropped),
        .brightness    (brightness),
        .bus           (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-buffer model: registered read, content equals address.
    always @(posedge clk) begin
        if (bus.mem_rd) mem_q <= bus.mem_addr;
        if (bus.mem_rd) rd_seen <= rd_seen + 1;
        if (frame_done) done_seen <= done_seen + 1;
    end
    assign bus.mem_data       = mem_q;
    assign bus.bitstream_read = rd_req;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] scale_word(input logic [47:0] w);
        logic [47:0] r;
        r = w;
`ifdef WS2812B_FRAME_STREAMER_BRIGHTNESS_EN
        // brightness 0x7F scales by 128/256
        for (int i = 0; i < 6; i++) r[8*i +: 8] = w[8*i +: 8] >> 1;
`endif
        return r;
    endfunction

    task automatic check_outputs_cleared(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_start_dropped"}, start_dropped, 0);
        check({tag, "_mem_rd"}, bus.mem_rd, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_bitstream"}, bus.bitstream, 0);
        check({tag, "_available"}, bus.bitstream_available, 0);
    endtask

    task automatic wait_avail();
        int n;
        n = 0;
        while (!bus.bitstream_available && n < 200) begin
            tick();
            n++;
        end
        check("avail_timeout", bus.bitstream_available, 1);
    endtask

    task automatic run_frame(input vec_t v, input int id);
        logic [47:0] exp_w [3];
        int n;
        int rd0;
        int dn0;
        bit stable;
        exp_w[0] = scale_word(v.w0);
        exp_w[1] = scale_word(v.w1);
        exp_w[2] = scale_word(v.w2);
        rd0 = rd_seen;
        dn0 = done_seen;
        start = 1'b1;
        bank_sel = v.bank;
        tick();
        start = 1'b0;
        check("busy_rise", busy, 1);
        check("first_mem_rd", bus.mem_rd, 1);
        check("first_mem_addr", bus.mem_addr, v.bank ? 64'h80 : 64'h00);
        n = 1;
        while (!bus.bitstream_available && n < 200) begin
            tick();
            n++;
        end
        check("first_word_latency", n, EXP_LAT);
        for (int w = 0; w < 3; w++) begin
            wait_avail();
            $display("[TB] frame %0d word %0d bitstream=0x%012h", id, w, bus.bitstream);
            check("word", bus.bitstream, exp_w[w]);
            if (w == 0 && v.restart) begin
                start = 1'b1;
                bank_sel = ~v.bank;
                tick();
                start = 1'b0;
                check("start_dropped_pulse", start_dropped, 1);
                tick();
                check("start_dropped_clear", start_dropped, 0);
            end
            if (w == 0 && v.hold > 0) begin
                stable = 1'b1;
                for (int c = 0; c < v.hold; c++) begin
                    tick();
                    if (bus.bitstream !== exp_w[0] || bus.bitstream_available !== 1'b1) stable = 1'b0;
                end
                check("bp_word_stable", stable, 1);
                check("bp_reads_two_words", rd_seen - rd0, 12);
                check("bp_mem_rd_idle", bus.mem_rd, 0);
            end
            repeat (v.delay) tick();
            rd_req = 1'b1;
            tick();
            rd_req = 1'b0;
        end
        check("frame_done_pulse", frame_done, 1);
        check("busy_fall", busy, 0);
        tick();
        check("frame_done_clear", frame_done, 0);
        check("frame_done_count", done_seen - dn0, 1);
        check("frame_read_count", rd_seen - rd0, 18);
    endtask

    initial begin
        int dn0;
        tests = 0;
        fails = 0;
        rd_seen = 0;
        done_seen = 0;
        reset = 1'b1;
        start = 1'b0;
        bank_sel = 1'b0;
        rd_req = 1'b0;
        brightness = 8'h7F;
        repeat (3) tick();
        check_outputs_cleared("reset");
        reset = 1'b0;
        tick();

        tbl[0] = '{1'b0, 2, 1'b0, 0,  48'h030405_000102, 48'h090A0B_060708, 48'h0F1011_0C0D0E};
        tbl[1] = '{1'b1, 0, 1'b0, 0,  48'h838485_808182, 48'h898A8B_868788, 48'h8F9091_8C8D8E};
        tbl[2] = '{1'b0, 1, 1'b0, 50, 48'h030405_000102, 48'h090A0B_060708, 48'h0F1011_0C0D0E};
        tbl[3] = '{1'b0, 3, 1'b1, 0,  48'h030405_000102, 48'h090A0B_060708, 48'h0F1011_0C0D0E};
        tbl[4] = '{1'b1, 0, 1'b1, 0,  48'h838485_808182, 48'h898A8B_868788, 48'h8F9091_8C8D8E};

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i], i);
            repeat (2) tick();
        end

        // Read pulse with nothing available, then reset after the first word is consumed.
        dn0 = done_seen;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("idle_read_ignored", bus.bitstream_available, 0);
        start = 1'b1;
        bank_sel = 1'b0;
        tick();
        start = 1'b0;
        tick();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        wait_avail();
        $display("[TB] reset-seq word 0 bitstream=0x%012h", bus.bitstream);
        check("early_read_word0", bus.bitstream, scale_word(48'h030405_000102));
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        reset = 1'b1;
        tick();
        check_outputs_cleared("midframe_reset");
        reset = 1'b0;
        repeat (5) tick();
        check("no_done_after_reset", done_seen - dn0, 0);
        run_frame(tbl[0], 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
